// File: rtl/rr_flag_arbiter_pkg.sv
// Shared types and defaults for the round-robin flag arbiter.
// Holds the FSM state encoding and a one-hot to index helper.
package rr_flag_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int N_DEFAULT        = 4;
  localparam int MAX_HOLD_DEFAULT = 15;
  localparam int CNT_W_DEFAULT    = 8;

  // OR-reduce the positions rather than priority-encode; the grant is
  // guaranteed one-hot, so this is cheaper and gives the same answer.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_flag_arbiter_pick.sv
// Rotating-priority picker: the first set request at or above ptr,
// wrapping modulo N, wins.
module rr_pick
  import rr_flag_arbiter_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     win,
  output logic             valid
);

  logic [N-1:0] rot_req;
  logic [N-1:0] rot_win;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    rot_req = N'({req, req} >> ptr);
    rot_win = rot_req & (~rot_req + N'(1));
    win     = N'(({rot_win, rot_win} << ptr) >> N);
    valid   = |req;
  end

endmodule

// File: rtl/rr_flag_arbiter.sv
// Round-robin owner of a shared set/clear flag, with a hold timeout that
// forces release after MAX_HOLD granted cycles.
module rr_flag_arbiter
  import rr_flag_arbiter_pkg::*;
#(
  parameter int N        = N_DEFAULT,
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] io_req,
  input  logic [N-1:0] io_set,
  input  logic [N-1:0] io_clr,
  output logic [N-1:0] io_gnt,
  output logic         io_s,
  output logic         io_busy,
  output logic         io_timeout
);

  localparam int PTR_W = $clog2(N);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(MAX_HOLD);
  localparam logic [PTR_W-1:0] PTR_TOP   = PTR_W'(N - 1);

  state_t             state_q, state_d;
  logic [N-1:0]       gnt_q, gnt_d;
  logic               s_q, s_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               timeout_q, timeout_d;

  logic [N-1:0]       pick_win;
  logic               pick_valid;
  logic               owner_req;
  logic               owner_set;
  logic               owner_clr;
  logic [PTR_W-1:0]   owner_ptr;
  logic [PTR_W-1:0]   ptr_after;

  rr_pick #(
    .N     (N),
    .PTR_W (PTR_W)
  ) u_pick (
    .req   (io_req),
    .ptr   (ptr_q),
    .win   (pick_win),
    .valid (pick_valid)
  );

  // Masking with the grant keeps non-owner commands away from the flag.
  always_comb begin
    owner_req = |(io_req & gnt_q);
    owner_set = |(io_set & gnt_q);
    owner_clr = |(io_clr & gnt_q);
    owner_ptr = PTR_W'(onehot_to_idx(8'(gnt_q)));
    ptr_after = (owner_ptr == PTR_TOP) ? '0 : owner_ptr + PTR_W'(1);
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    s_d       = s_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          gnt_d   = pick_win;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = ptr_after;
          cnt_d   = '0;
        end else begin
          if (owner_set) begin
            s_d = 1'b1;
          end else if (owner_clr) begin
            s_d = 1'b0;
          end
          // The command on the last held cycle still lands before release.
          if (cnt_q == HOLD_LAST) begin
            state_d   = IDLE;
            gnt_d     = '0;
            ptr_d     = ptr_after;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else if (cnt_q != HOLD_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      s_q       <= 1'b0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      s_q       <= s_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
    end
  end

  assign io_gnt     = gnt_q;
  assign io_s       = s_q;
  assign io_busy    = (state_q == GRANT);
  assign io_timeout = timeout_q;

endmodule

// File: tb/tb_rr_flag_arbiter.sv
// Scenario tasks plus randomized traffic, all checked against a
// cycle-level ownership model of the arbiter.
module tb_rr_flag_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 15;

  logic         clk;
  logic         reset_n;
  logic [N-1:0] io_req;
  logic [N-1:0] io_set;
  logic [N-1:0] io_clr;
  logic [N-1:0] io_gnt;
  logic         io_s;
  logic         io_busy;
  logic         io_timeout;

  int checks;
  int fails;

  // Model: who owns the flag, how many cycles they have held it so far,
  // whose turn is next, the flag value and the timeout pulse.
  int m_owner;
  int m_held;
  int m_ptr;
  bit m_s;
  bit m_to;

  logic [6:0] obs;
  logic [6:0] exp_v;

  rr_flag_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .io_req     (io_req),
    .io_set     (io_set),
    .io_clr     (io_clr),
    .io_gnt     (io_gnt),
    .io_s       (io_s),
    .io_busy    (io_busy),
    .io_timeout (io_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_owner = -1;
    m_held  = 0;
    m_ptr   = 0;
    m_s     = 1'b0;
    m_to    = 1'b0;
  endfunction

  function automatic void model_step(input logic [N-1:0] req, input logic [N-1:0] set,
                                     input logic [N-1:0] clr);
    if (m_owner < 0) begin
      m_to = 1'b0;
      for (int off = 0; off < N; off++) begin
        if (m_owner < 0 && req[(m_ptr + off) % N]) begin
          m_owner = (m_ptr + off) % N;
          m_held  = 1;
        end
      end
    end else if (!req[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_to    = 1'b0;
    end else begin
      if (set[m_owner]) m_s = 1'b1;
      else if (clr[m_owner]) m_s = 1'b0;
      if (m_held == MAX_HOLD) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_to    = 1'b1;
      end else begin
        m_held = m_held + 1;
        m_to   = 1'b0;
      end
    end
  endfunction

  function automatic logic [6:0] model_vec();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return {g, m_s, (m_owner >= 0), m_to};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(io_req, io_set, io_clr);
    #1;
    obs   = {io_gnt, io_s, io_busy, io_timeout};
    exp_v = model_vec();
  endtask

  task automatic applyStimulus(input logic [N-1:0] req, input logic [N-1:0] set,
                               input logic [N-1:0] clr);
    io_req = req;
    io_set = set;
    io_clr = clr;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    applyStimulus('0, '0, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({io_gnt, io_s, io_busy, io_timeout} !== 7'b0) begin
      fails++;
      $display("[TB] FAIL reset_state: got %b expected %b", {io_gnt, io_s, io_busy, io_timeout}, 7'b0);
    end
    applyStimulus(4'b0001, 4'b0000, 4'b0000);
    tick();
    applyStimulus(4'b0001, 4'b0001, 4'b0000);
    tick();
    checks++;
    if (obs !== exp_v) begin
      fails++;
      $display("[TB] FAIL reset_preset: got %b expected %b", obs, exp_v);
    end
    // Pull reset mid-cycle, away from any clock edge.
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({io_gnt, io_s, io_busy, io_timeout} !== 7'b0) begin
      fails++;
      $display("[TB] FAIL reset_async: got %b expected %b", {io_gnt, io_s, io_busy, io_timeout}, 7'b0);
    end
    applyStimulus(4'b1111, 4'b0000, 4'b0000);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    tick();
    checks++;
    if (io_gnt !== 4'b0001 || obs !== exp_v) begin
      fails++;
      $display("[TB] FAIL reset_first_grant: got %b expected gnt 0001 / %b", obs, exp_v);
    end
  endtask

  task automatic test_round_robin();
    int starts[$];
    logic [N-1:0] prev;
    logic [N-1:0] req;
    int order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    prev = '0;
    for (int c = 0; c < 20; c++) begin
      req = 4'b1111;
      if (m_owner >= 0 && m_held == 3) req = req & ~(4'b0001 << m_owner);
      applyStimulus(req, '0, '0);
      tick();
      checks++;
      if (obs !== exp_v) begin
        fails++;
        $display("[TB] FAIL rr_cycle %0d: got %b expected %b", c, obs, exp_v);
      end
      if (prev == '0 && io_gnt != '0) begin
        for (int i = 0; i < N; i++) if (io_gnt[i]) starts.push_back(i);
      end
      prev = io_gnt;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= starts.size()) begin
        fails++;
        $display("[TB] FAIL rr_order[%0d]: got none expected %0d", i, order[i]);
      end else if (starts[i] != order[i]) begin
        fails++;
        $display("[TB] FAIL rr_order[%0d]: got %0d expected %0d", i, starts[i], order[i]);
      end
    end
  endtask

  task automatic test_flag_ownership();
    logic [N-1:0] sets[6] = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
    logic [N-1:0] clrs[6] = '{4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0100, 4'b0000};
    logic         s_exp[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      applyStimulus(4'b0100, sets[c], clrs[c]);
      tick();
      checks++;
      if (obs !== exp_v || io_s !== s_exp[c]) begin
        fails++;
        $display("[TB] FAIL flag_step %0d: got %b s=%b expected %b s=%b", c, obs, io_s, exp_v, s_exp[c]);
      end
    end
  endtask

  task automatic test_timeout();
    int on1;
    int to_cnt;
    int g3_at;
    do_reset();
    on1 = 0;
    to_cnt = 0;
    g3_at = -1;
    applyStimulus(4'b1010, '0, '0);
    for (int c = 1; c <= 20; c++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin
        fails++;
        $display("[TB] FAIL timeout_cycle %0d: got %b expected %b", c, obs, exp_v);
      end
      if (io_gnt == 4'b0010) on1++;
      if (io_timeout) to_cnt++;
      if (io_gnt == 4'b1000 && g3_at < 0) g3_at = c;
    end
    checks++;
    if (on1 != MAX_HOLD || to_cnt != 1 || g3_at != MAX_HOLD + 2) begin
      fails++;
      $display("[TB] FAIL timeout_summary: got hold=%0d pulses=%0d g3_at=%0d expected %0d 1 %0d",
               on1, to_cnt, g3_at, MAX_HOLD, MAX_HOLD + 2);
    end
  endtask

  task automatic test_single();
    int on0;
    int to_cnt;
    do_reset();
    on0 = 0;
    to_cnt = 0;
    applyStimulus(4'b0001, '0, '0);
    for (int c = 1; c <= 40; c++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin
        fails++;
        $display("[TB] FAIL single_cycle %0d: got %b expected %b", c, obs, exp_v);
      end
      if (io_gnt == 4'b0001) on0++;
      if (io_timeout) to_cnt++;
    end
    checks++;
    if (on0 != 38 || to_cnt != 2) begin
      fails++;
      $display("[TB] FAIL single_summary: got on=%0d pulses=%0d expected 38 2", on0, to_cnt);
    end
  endtask

  task automatic test_release_race();
    do_reset();
    applyStimulus(4'b0001, '0, '0);
    tick();
    applyStimulus(4'b0000, 4'b0001, 4'b0000);
    tick();
    checks++;
    if (io_s !== 1'b0 || io_gnt !== 4'b0000 || obs !== exp_v) begin
      fails++;
      $display("[TB] FAIL release_race: got s=%b gnt=%b expected s=0 gnt=0000", io_s, io_gnt);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] req;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req = 4'($urandom_range(0, 15));
      if (m_owner >= 0 && $urandom_range(0, 7) != 0) req = req | (4'b0001 << m_owner);
      applyStimulus(req, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      tick();
      checks++;
      if (obs !== exp_v) begin
        fails++;
        $display("[TB] FAIL random_cycle %0d: got %b expected %b", c, obs, exp_v);
      end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    reset_n = 1'b0;
    applyStimulus('0, '0, '0);
    model_reset();
    test_reset();
    test_round_robin();
    test_flag_ownership();
    test_timeout();
    test_single();
    test_release_race();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
